vec_add_arb: RTL
================

Name: vec_add_arb

Overview:
- Round-robin arbiter/sequencer that shares one vec_add engine (vector + s-vector XOR/P251 add) among NUM_REQ requesters.
- Grants one job at a time and pulses the engine start.
- Steers the engine's memory windows by exporting the selected requester's index and base addresses.
- Waits for engine done, returns a per-requester completion pulse, and guards the engine with a watchdog.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VEC_WORDS, 13, PROC_SIZE-bit words per vector (L1: 104 bytes / 8 = 13); the stride between requester vector buffers.
- S_STRIDE, 256, byte stride between requester s-buffers.
- TIMEOUT, 1023, max BUSY cycles before abort; 0 disables the watchdog.
- SEL_W, `CLOG2(NUM_REQ), index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req  in  NUM_REQ  level request per requester; held until its o_done.
- i_abort  in  1  synchronous software abort of the current job.
- o_gnt  out  NUM_REQ  one-hot grant, registered.
- o_sel  out  SEL_W  index of the granted requester.
- o_vec_base  out  `CLOG2(NUM_REQ*VEC_WORDS)  o_sel*VEC_WORDS, registered.
- o_s_base  out  `CLOG2(NUM_REQ*S_STRIDE)  o_sel*S_STRIDE, registered.
- o_eng_start  out  1  one-cycle engine start pulse.
- o_eng_rst  out  1  one-cycle engine reset pulse on abort/timeout.
- i_eng_done  in  1  engine completion pulse.
- o_done  out  NUM_REQ  one-hot completion pulse.
- o_err  out  1  qualifies o_done: 1 means the job was aborted or timed out.
- o_busy  out  1  high in START/BUSY/RESP.

Behaviour:
- Reset (async, i_rst=1): state=IDLE, rr_ptr=0, timer=0. All outputs 0: o_gnt, o_sel, o_vec_base, o_s_base, o_eng_start, o_eng_rst, o_done, o_err, o_busy.
- IDLE:
  - If any i_req bit is set, pick the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - At the next edge, register o_sel, o_gnt, the bases and o_eng_start=1, and go to START.
  - Latency from req to grant/start: 1 cycle.
- START (1 cycle): o_eng_start returns to 0, timer=0, go to BUSY. Grant and bases stay stable until RESP ends.
- BUSY:
  - timer increments each cycle.
  - i_eng_done=1: go to RESP with err=0.
  - i_abort=1, or (TIMEOUT≠0 and timer==TIMEOUT): pulse o_eng_rst for 1 cycle and go to RESP with err=1.
  - If done and abort occur in the same cycle, done wins (err=0).
- RESP (1 cycle):
  - o_done[sel]=1; o_err=err.
  - o_gnt is cleared at the exit edge.
  - rr_ptr=(sel+1) mod NUM_REQ; go to IDLE.
- Requester duty: drop i_req in the cycle o_done is seen. A request still high in the IDLE cycle after RESP is treated as a new job.
- Requests arriving during START/BUSY/RESP wait; none are lost, because requests are levels.
- i_eng_done outside BUSY is ignored. i_abort outside BUSY is ignored.
- A requester dropping i_req mid-job does not cancel the job; o_done is still issued.
- Minimum back-to-back period between jobs: 3 cycles of overhead (IDLE, START, RESP) plus engine time.
- o_busy=1 in START, BUSY and RESP.
- Base products are computed at grant time from o_sel. Width is `CLOG2 of the full buffer span; no overflow is possible.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE=0, S_START=1, S_BUSY=2, S_RESP=3;
  - the per-parameter-set VEC_WORDS table (L1 13, L3 20, L5 26).
- One sub-module: rr_pick. It is a combinational priority search over i_req starting at rr_ptr, returning index and valid. Verify it standalone.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: grant req0, assert i_rst in cycle 5 of BUSY.
  - Expected: all outputs 0 immediately (async); no o_done; next req1 granted with o_sel=1.
- Single job, NUM_REQ=4:
  - Stimulus: i_req=4'b0100; engine done 20 cycles after start.
  - Expected: o_gnt=4'b0100, o_sel=2, o_vec_base=26, o_s_base=512 and o_eng_start 1 cycle after req; o_done=4'b0100 one cycle after i_eng_done, o_err=0.
- Fairness:
  - Stimulus: i_req=4'b1111 held; each requester drops on its done.
  - Expected: grant order 0,1,2,3. Then re-raise 4'b1001 with rr_ptr=0: grant 0 then 3.
- Timeout:
  - Stimulus: TIMEOUT=15, never assert i_eng_done.
  - Expected: o_eng_rst pulses when timer=15; o_done[sel]=1 with o_err=1 the next cycle; state returns to IDLE.
- Abort/done collision:
  - Stimulus: i_abort and i_eng_done in the same BUSY cycle.
  - Expected: o_err=0, no o_eng_rst. i_abort alone in IDLE: no effect.
- Spurious done:
  - Stimulus: i_eng_done pulse in IDLE and in START.
  - Expected: ignored; the job completes only on the BUSY-state done.

Source files
------------

// File: rtl/vec_add_arb_pkg.sv
// ============================================================================
// Module  : vec_add_arb_pkg
// Brief   : Shared state encoding and vector-length table for vec_add_arb.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package vec_add_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LVL_L1 = 2'd0,
    LVL_L3 = 2'd1,
    LVL_L5 = 2'd2
  } level_t;

  // Words per vector for each parameter set (bytes / 8).
  localparam int c_VEC_WORDS_L1 = 13;
  localparam int c_VEC_WORDS_L3 = 20;
  localparam int c_VEC_WORDS_L5 = 26;

  function automatic int vec_words(input level_t lvl);
    case (lvl)
      LVL_L3:  return c_VEC_WORDS_L3;
      LVL_L5:  return c_VEC_WORDS_L5;
      default: return c_VEC_WORDS_L1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_add_arb_rr_pick.sv
// ============================================================================
// Module  : vec_add_arb_rr_pick
// Brief   : Combinational round-robin search over i_req starting at i_ptr.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vec_add_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_off;
  int                 w_sum;

  // Rotate so bit 0 is the pointer position, take the lowest set bit, then
  // map the offset back to an absolute index with a single wrap.
  always_comb begin
    w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
    o_valid = |i_req;
    w_off   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = k;
      end
    end
    w_sum = int'(i_ptr) + w_off;
    if (w_sum >= NUM_REQ) begin
      w_sum = w_sum - NUM_REQ;
    end
    o_idx = SEL_W'(w_sum);
  end

endmodule

`default_nettype wire

// File: rtl/vec_add_arb.sv
// ============================================================================
// Module  : vec_add_arb
// Brief   : Round-robin sequencer sharing one vec_add engine among requesters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vec_add_arb
  import vec_add_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int VEC_WORDS = vec_words(LVL_L1),
  parameter  int S_STRIDE  = 256,
  parameter  int TIMEOUT   = 1023,
  parameter  int SEL_W     = $clog2(NUM_REQ),
  localparam int VB_W      = $clog2(NUM_REQ * VEC_WORDS),
  localparam int SB_W      = $clog2(NUM_REQ * S_STRIDE)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_abort,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0]   o_sel,
  output logic [VB_W-1:0]    o_vec_base,
  output logic [SB_W-1:0]    o_s_base,
  output logic               o_eng_start,
  output logic               o_eng_rst,
  input  logic               i_eng_done,
  output logic [NUM_REQ-1:0] o_done,
  output logic               o_err,
  output logic               o_busy
);

  localparam int                 TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]      c_TIMEOUT = TW'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] c_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_rr_ptr;
  logic [TW-1:0]        r_timer;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [SEL_W-1:0]     r_sel;
  logic [VB_W-1:0]      r_vec_base;
  logic [SB_W-1:0]      r_s_base;
  logic                 r_eng_start;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;

  logic [SEL_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_timeout;
  logic                 w_launch;
  logic                 w_finish;
  logic                 w_fail;
  logic                 w_eng_rst;

  vec_add_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_timeout = (TIMEOUT != 0) && (r_timer == c_TIMEOUT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Engine done has priority over abort/timeout when both land together.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    w_fail      = 1'b0;
    w_eng_rst   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = S_START;
          w_launch    = 1'b1;
        end
      end
      S_START: begin
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (i_eng_done) begin
          w_state_nxt = S_RESP;
          w_finish    = 1'b1;
        end else if (i_abort || w_timeout) begin
          w_state_nxt = S_RESP;
          w_finish    = 1'b1;
          w_fail      = 1'b1;
          w_eng_rst   = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_timer     <= '0;
      r_gnt       <= '0;
      r_sel       <= '0;
      r_vec_base  <= '0;
      r_s_base    <= '0;
      r_eng_start <= 1'b0;
      r_done      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_eng_start <= w_launch;
      r_done      <= '0;
      r_err       <= 1'b0;

      if (w_launch) begin
        r_sel      <= w_pick_idx;
        r_gnt      <= c_ONE << w_pick_idx;
        r_vec_base <= VB_W'(int'(w_pick_idx) * VEC_WORDS);
        r_s_base   <= SB_W'(int'(w_pick_idx) * S_STRIDE);
      end

      if (r_state == S_START) begin
        r_timer <= '0;
      end else if (r_state == S_BUSY) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_finish) begin
        r_done <= r_gnt;
        r_err  <= w_fail;
      end

      // Sel and bases are left holding; only the grant drops after RESP.
      if (r_state == S_RESP) begin
        r_gnt    <= '0;
        r_rr_ptr <= (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_sel       = r_sel;
  assign o_vec_base  = r_vec_base;
  assign o_s_base    = r_s_base;
  assign o_eng_start = r_eng_start;
  assign o_eng_rst   = w_eng_rst;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
